// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for uart_rx and uart_tx
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-FF synchroniser for the serial line plus falling-edge detect
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // All stages reset high so a held reset looks like an idle line
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign o_sync = sync_q;
    assign o_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ack output; UART_RX_PARITY_EN adds even parity
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    input  logic       i_data_ack,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic           rx;
    logic           rx_fall;
    uart_rx_state_t state_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
`ifdef UART_RX_PARITY_EN
    logic           parity_err_q;
`endif

    uart_rx_sync u_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_async   (i_uart_rx),
        .o_sync    (rx),
        .o_fall    (rx_fall)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            o_frame_err <= 1'b0;
            // Ack is applied first so a byte completing in the same cycle can take its place
            if (i_data_ack) begin
                o_data_valid <= 1'b0;
                o_overrun    <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (rx_fall) begin
                        cnt_q   <= '0;
                        state_q <= START;
                    end
                end

                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (!rx) begin
                            bit_idx_q <= '0;
                            state_q   <= DATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q        <= '0;
                        parity_err_q <= (^shift_q) ^ rx;
                        state_q      <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (!rx) begin
                            o_frame_err <= 1'b1;
                            state_q     <= BREAK;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_err_q) begin
                            o_frame_err <= 1'b1;
                            state_q     <= IDLE;
`endif
                        end else begin
                            if (!o_data_valid || i_data_ack) begin
                                o_data       <= shift_q;
                                o_data_valid <= 1'b1;
                            end else begin
                                o_overrun <= 1'b1;
                            end
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                BREAK: begin
                    if (rx) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
